// File: rtl/ahb2apb_bridge_pkg.sv
// Shared AHB/APB constants, bridge FSM encoding and the APB4 strobe helper.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Byte lanes touched by a write; reads never assert any strobe.
  function automatic logic [3:0] strobe_for(input logic       write,
                                            input logic [2:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'b0000;
    if (write) begin
      case (size)
        HSIZE_BYTE: strb = 4'b0001 << addr_lo;
        HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
        default:    strb = 4'b1111;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS per AHB transfer,
// with a two-cycle ERROR response for slave errors, unmapped slots and timeouts.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int SEL_BITS   = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hsel,
  input  logic [31:0]             haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [31:0]             hwdata,
  output logic [31:0]             hrdata,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [31:0]             paddr,
  output logic [NUM_SLAVES-1:0]   psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [31:0]             pwdata,
  output logic [3:0]              pstrb,
  input  logic [32*NUM_SLAVES-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]   pready,
  input  logic [NUM_SLAVES-1:0]   pslverr
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [SEL_BITS-1:0]     idx_q, idx_d;
  logic [31:0]             paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [3:0]              pstrb_q, pstrb_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [31:0]             hrdata_q, hrdata_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;

  logic                    accept;
  logic                    legal;
  logic [SEL_BITS-1:0]     addr_idx;
  logic                    sel_ready;
  logic                    sel_err;
  logic [31:0]             sel_rdata;

  // Pick the addressed slave's response lines using the registered index.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[32*i +: 32];
      end
    end
  end

  // Next-state logic plus the registered APB/AHB output values derived from it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;

    addr_idx = haddr[SEL_LSB +: SEL_BITS];
    legal    = (32'(addr_idx) < 32'(NUM_SLAVES)) && (hsize <= HSIZE_WORD);
    accept   = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && hreadyout_q &&
               (state_q == ST_IDLE || state_q == ST_DONE);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (legal) begin
            state_d  = ST_SETUP;
            cnt_d    = '0;
            idx_d    = addr_idx;
            paddr_d  = haddr;
            pwrite_d = hwrite;
            pstrb_d  = strobe_for(hwrite, hsize, haddr[1:0]);
          end else begin
            state_d = ST_ERR1;
          end
        end
      end
      ST_SETUP: begin
        pwdata_d = hwdata;
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (sel_ready) begin
          if (sel_err) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!pwrite_q) hrdata_d = sel_rdata;
          end
        end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    psel_d = '0;
    if (state_d == ST_SETUP || state_d == ST_ACCESS) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        psel_d[i] = (idx_d == SEL_BITS'(i));
      end
    end
    penable_d   = (state_d == ST_ACCESS);
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // All bridge state and outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: directed scenarios plus randomized
// transfers, checked against a transaction-level model of the bridge.
module tb_ahb2apb_bridge;
  import ahb_apb_pkg::*;

  localparam int NS  = 4;
  localparam int TMO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hsel;
  logic [31:0]     haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [31:0]     hwdata;
  logic [31:0]     hrdata;
  logic            hreadyout;
  logic            hresp;
  logic [31:0]     paddr;
  logic [NS-1:0]   psel;
  logic            penable;
  logic            pwrite;
  logic [31:0]     pwdata;
  logic [3:0]      pstrb;
  logic [32*NS-1:0] prdata;
  logic [NS-1:0]   pready;
  logic [NS-1:0]   pslverr;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_hrdata = 32'h0;

  always #5 clk = ~clk;

  ahb2apb_bridge #(
    .NUM_SLAVES(NS),
    .SEL_LSB(12),
    .SEL_BITS(3),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Global time limit so a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-target slaves get random noise; the target gets the requested response.
  task automatic drive_slaves(input int tgt, input logic rdy, input logic err, input logic [31:0] rd);
    for (int i = 0; i < NS; i++) begin
      pready[i]           = 1'($urandom_range(0, 1));
      pslverr[i]          = 1'($urandom_range(0, 1));
      prdata[32*i +: 32]  = $urandom;
    end
    if (tgt >= 0 && tgt < NS) begin
      pready[tgt]          = rdy;
      pslverr[tgt]         = err;
      prdata[32*tgt +: 32] = rd;
    end
  endtask

  task automatic go_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  // One AHB transfer; waits = pready-low ACCESS cycles before the slave answers.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, input int waits, input logic err,
                         input logic [31:0] rd, input string name);
    int         idx, nbytes, lo, low, acc, exp_low, exp_acc, tgt;
    logic       mapped, exp_err, seen;
    logic [3:0] exp_strb, exp_psel;

    idx    = int'(addr[14:12]);
    mapped = (idx < NS) && (size <= 3'd2);
    tgt    = mapped ? idx : -1;
    nbytes = 1 << size;
    lo     = int'(addr[1:0]);
    exp_strb = 4'b0000;
    if (wr && mapped) exp_strb = 4'(((1 << nbytes) - 1) << ((lo / nbytes) * nbytes));
    exp_psel = mapped ? 4'(1 << idx) : 4'b0000;
    if (!mapped) begin
      exp_err = 1'b1; exp_low = 1; exp_acc = 0;
    end else if (waits >= TMO) begin
      exp_err = 1'b1; exp_low = TMO + 2; exp_acc = TMO;
    end else if (err) begin
      exp_err = 1'b1; exp_low = waits + 3; exp_acc = waits + 1;
    end else begin
      exp_err = 1'b0; exp_low = waits + 2; exp_acc = waits + 1;
      if (!wr) exp_hrdata = rd;
    end

    total++;
    if (hreadyout !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s ready_before: got %b want 1", name, hreadyout);
    end
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hwdata = $urandom;
    drive_slaves(tgt, 1'b0, 1'b0, 32'h0);
    tick();
    htrans = HTRANS_IDLE;
    haddr  = $urandom;
    hwrite = 1'($urandom_range(0, 1));
    hsize  = 3'($urandom_range(0, 3));
    hwdata = wdata;

    low = 0; acc = 0; seen = 1'b0;
    while (hreadyout === 1'b0 && low < 64) begin
      low++;
      total++;
      if (hresp !== (exp_err && low == exp_low)) begin
        bad++;
        $display("[TB] FAIL %s hresp_wait cycle %0d: got %b want %b", name, low, hresp, exp_err && low == exp_low);
      end
      if (psel !== '0) begin
        seen = 1'b1;
        total++;
        if ({psel, paddr, pwrite, pstrb} !== {exp_psel, addr, wr, exp_strb}) begin
          bad++;
          $display("[TB] FAIL %s apb_ctrl: got psel=%b paddr=%h pwrite=%b pstrb=%b want psel=%b paddr=%h pwrite=%b pstrb=%b",
                   name, psel, paddr, pwrite, pstrb, exp_psel, addr, wr, exp_strb);
        end
        if (penable === 1'b1) begin
          acc++;
          if (wr) begin
            total++;
            if (pwdata !== wdata) begin
              bad++;
              $display("[TB] FAIL %s pwdata: got %h want %h", name, pwdata, wdata);
            end
          end
        end
      end else begin
        total++;
        if (penable !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s penable_without_psel: got %b want 0", name, penable);
        end
      end
      drive_slaves(tgt, (penable === 1'b1) && (acc == waits + 1), err, rd);
      if (low > 1) hwdata = $urandom;
      tick();
    end
    drive_slaves(tgt, 1'b0, 1'b0, 32'h0);

    total++;
    if (low != exp_low) begin
      bad++;
      $display("[TB] FAIL %s wait_states: got %0d want %0d", name, low, exp_low);
    end
    total++;
    if (hresp !== exp_err) begin
      bad++;
      $display("[TB] FAIL %s hresp_final: got %b want %b", name, hresp, exp_err);
    end
    total++;
    if (hrdata !== exp_hrdata) begin
      bad++;
      $display("[TB] FAIL %s hrdata: got %h want %h", name, hrdata, exp_hrdata);
    end
    total++;
    if (seen !== mapped || acc != exp_acc) begin
      bad++;
      $display("[TB] FAIL %s apb_activity: got psel_seen=%b access=%0d want psel_seen=%b access=%0d",
               name, seen, acc, mapped, exp_acc);
    end
    if (exp_err) begin
      // An address phase here would be ignored, so present nothing in ERR2.
      go_idle();
      tick();
      total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s err_exit: got ready=%b resp=%b want ready=1 resp=0", name, hreadyout, hresp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_1000; hwrite = 1'b1;
    hsize = HSIZE_WORD; hwdata = $urandom;
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    total++;
    if ({hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata, pstrb} !==
        {1'b1, 1'b0, 32'h0, 4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0}) begin
      bad++;
      $display("[TB] FAIL reset_values: got ready=%b resp=%b hrdata=%h psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%b want ready=1 resp=0 rest 0",
               hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata, pstrb);
    end
    go_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_write();
    do_xfer(32'h0000_1004, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, "word_write");
    go_idle(); tick();
  endtask

  task automatic test_strobes();
    do_xfer(32'h0000_2003, 1'b1, HSIZE_BYTE, 32'hA5A5_A5A5, 0, 1'b0, 32'h0, "byte_write");
    go_idle(); tick();
    do_xfer(32'h0000_3002, 1'b1, HSIZE_HALF, 32'h1234_CAFE, 1, 1'b0, 32'h0, "half_write");
    go_idle(); tick();
    do_xfer(32'h0000_1008, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hFACE_0001, "word_read");
    go_idle(); tick();
  endtask

  task automatic test_wait_read();
    do_xfer(32'h0000_0000, 1'b0, HSIZE_WORD, 32'h0, 3, 1'b0, 32'h1234_5678, "wait_read");
    go_idle(); tick();
  endtask

  task automatic test_errors();
    do_xfer(32'h0000_1010, 1'b1, HSIZE_WORD, 32'h5555_AAAA, 1, 1'b1, 32'h0, "slverr");
    do_xfer(32'h0000_5000, 1'b1, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0, "unmapped");
    do_xfer(32'h0000_2000, 1'b0, 3'd3, 32'h0, 0, 1'b0, 32'h0, "bad_hsize");
  endtask

  task automatic test_timeout();
    do_xfer(32'h0000_3000, 1'b0, HSIZE_WORD, 32'h0, 20, 1'b0, 32'hBAD0_BAD0, "timeout");
    do_xfer(32'h0000_3004, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0BAD_F00D, "after_timeout");
    go_idle(); tick();
  endtask

  task automatic test_back_to_back();
    do_xfer(32'h0000_2008, 1'b1, HSIZE_WORD, 32'h2222_2222, 0, 1'b0, 32'h0, "b2b_first");
    do_xfer(32'h0000_300C, 1'b1, HSIZE_HALF, 32'h3333_3333, 2, 1'b0, 32'h0, "b2b_second");
    go_idle(); tick();
  endtask

  task automatic test_busy();
    hsel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      htrans = (i == 1) ? HTRANS_IDLE : HTRANS_BUSY;
      haddr  = 32'h0000_1000;
      tick();
      total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== '0) begin
        bad++;
        $display("[TB] FAIL busy_okay: got ready=%b resp=%b psel=%b want ready=1 resp=0 psel=0", hreadyout, hresp, psel);
      end
    end
    go_idle(); tick();
  endtask

  task automatic test_reset_mid();
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_1000; hwrite = 1'b1; hsize = HSIZE_WORD;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    tick();
    go_idle(); hwdata = 32'h7777_7777;
    tick();
    total++;
    if (penable !== 1'b1 || psel !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL reset_mid_access: got psel=%b pen=%b want psel=0010 pen=1", psel, penable);
    end
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick();
    exp_hrdata = 32'h0;
    total++;
    if (psel !== '0 || penable !== 1'b0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got psel=%b pen=%b ready=%b resp=%b want 0 0 1 0", psel, penable, hreadyout, hresp);
    end
    rst_n = 1'b1;
    tick();
    do_xfer(32'h0000_1000, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h6060_0606, "after_reset_mid");
    go_idle(); tick();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      addr       = $urandom;
      addr[14:12] = 3'($urandom_range(0, 5));
      do_xfer(addr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6) == 0 ? 3 : $urandom_range(0, 2)),
              $urandom, int'($urandom_range(0, 5)), ($urandom_range(0, 6) == 0), $urandom, "random");
      if ($urandom_range(0, 2) == 0) begin
        hsel   = 1'($urandom_range(0, 1));
        htrans = 2'($urandom_range(0, 1));
        tick();
        total++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== '0) begin
          bad++;
          $display("[TB] FAIL random_gap: got ready=%b resp=%b psel=%b want 1 0 0", hreadyout, hresp, psel);
        end
      end
    end
    go_idle(); tick();
  endtask

  initial begin
    hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
    prdata = '0; pready = '0; pslverr = '0;
    test_reset();
    test_word_write();
    test_strobes();
    test_wait_read();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

AHB-Lite slave to APB4 master bridge sitting directly downstream of the core's data AHB master port (d_haddr … d_hready). It converts each single AHB transfer into one APB SETUP/ACCESS sequence to one of NUM_SLAVES peripherals, for example the interrupt keys and the timer. It stretches the AHB data phase with hreadyout until the APB slave completes, and reports APB errors, unmapped slots and hung slaves as a two-cycle AHB ERROR response.

## Interface
- NUM_SLAVES, 4: number of APB slaves; one psel bit per slave.
- SEL_LSB, 12: lowest haddr bit of the slave index field.
- SEL_BITS, 3: width of the slave index field haddr[SEL_LSB +: SEL_BITS]. An index ≥ NUM_SLAVES is unmapped.
- TIMEOUT, 255: maximum number of ACCESS cycles before the bridge aborts the transfer. Range 1..255.
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- hsel  in  1  bridge selected
- haddr  in  32  AHB address
- htrans  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- hwrite  in  1  1 = write
- hsize  in  3  0 = byte, 1 = half, 2 = word
- hwdata  in  32  write data, valid in the data phase
- hrdata  out  32  read data
- hreadyout  out  1  data-phase completion
- hresp  out  1  1 = ERROR
- paddr  out  32  APB address (registered haddr)
- psel  out  NUM_SLAVES  one-hot slave select
- penable  out  1  APB ACCESS phase
- pwrite  out  1  APB direction
- pwdata  out  32  APB write data
- pstrb  out  4  APB4 byte strobes
- prdata  in  32*NUM_SLAVES  slave i read data at [32*i +: 32]
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error

## Operation
- Valid address phase: hsel & htrans[1] & hreadyout. It is accepted only in IDLE or DONE. On acceptance the bridge registers haddr, hwrite, hsize and the slave index.
- Other htrans values while selected (IDLE, BUSY) get a zero-wait OKAY response and cause no APB activity.
- FSM states: IDLE, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE/DONE → SETUP on a valid, mapped address phase with hsize ≤ 2.
- IDLE/DONE → ERR1 on an unmapped index or hsize > 2. No psel is asserted in this case.
- SETUP: psel[idx]=1, penable=0, pwdata ← hwdata (captured this cycle). Next state is ACCESS.
- ACCESS: penable=1 and the timeout counter increments.
  - pready[idx]=1 and pslverr[idx]=0: hrdata ← prdata slice (reads only), go to DONE.
  - pready[idx]=1 and pslverr[idx]=1: go to ERR1.
  - counter reaches TIMEOUT with pready still low: drop psel/penable, go to ERR1.
- DONE: hreadyout=1, hresp=0. Returns to IDLE unless a new transfer is accepted.
- ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1. ERR2 → IDLE. An address phase presented during ERR2 is ignored; the master must re-present it.
- pstrb on writes:
  - byte: 4'b0001 << haddr[1:0]
  - half: 4'b0011 << {haddr[1],1'b0}
  - word: 4'b1111
- pstrb on reads: 0.
- paddr, pwrite and pstrb hold steady from SETUP through the end of ACCESS.
- hrdata holds its last captured value. It updates only on a read completion.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, state=IDLE, counter=0.
- Reset asserted mid-transfer forces IDLE at the next edge. psel and penable are 0 after that edge, with no AHB response given.
- Zero-wait slave: address phase at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, DONE at cycle 3 (hreadyout=1, hrdata valid). hreadyout is low in cycles 1–2, which gives 2 wait states.
- Each pready-low cycle in ACCESS adds one wait state.
- Back-to-back: a transfer accepted in DONE enters SETUP on the next cycle. APB has no idle gap beyond the DONE cycle.
- Timeout: with TIMEOUT=N, ERR1 occurs N cycles after ACCESS is entered. The counter clears on entry to SETUP.

## Structure
- Package ahb_apb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HSIZE_BYTE/HALF/WORD constants
  - FSM state encoding
  - strobe-generation function
- Single module with no sub-modules. prdata/pready/pslverr are selected by the registered index.

## Test plan
- Word write: haddr=0x0000_1004, hwdata=0xDEADBEEF, slave 1 pready=1 → psel=4'b0010 in cycles 1–2, penable in cycle 2, pstrb=4'b1111, pwdata=0xDEADBEEF; hreadyout=1 and hresp=0 in cycle 3.
- Byte write: haddr=0x0000_2003, hsize=0 → pstrb=4'b1000. Half write: haddr=0x…02, hsize=1 → pstrb=4'b1100. Read: pstrb=0.
- Read from slave 0 with pready low for 3 ACCESS cycles and prdata=0x12345678 → hreadyout low for 5 cycles, then hrdata=0x12345678 with hresp=0.
- Errors:
  - pslverr=1 at completion → ERR1 (hresp=1, hreadyout=0), then ERR2 (hresp=1, hreadyout=1).
  - haddr=0x0000_5000 (index 5, unmapped) → same ERROR pair with psel never asserted.
- Slave stuck with pready=0 and TIMEOUT=4 → psel drops after 4 ACCESS cycles, ERROR response follows, next transfer completes normally.
- Back-to-back writes to slaves 2 and 3, plus htrans=BUSY while selected (→ OKAY, no psel). Reset asserted during ACCESS → psel=0 and hreadyout=1 after the edge.
